// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - pointer/hit-test inputs and game-state outputs of game_flow_ctrl
interface game_flow_ctrl_if #(
    parameter int TIME_W = 12,
    parameter int LVL_W  = 2
);
    logic              mouse_left;
    logic [3:0]        mouse_on_btn;
    logic              board_valid;
    logic              entry_wrong;
    logic [2:0]        state;
    logic              game_init;
    logic [LVL_W-1:0]  level;
    logic [TIME_W-1:0] elapsed_sec;
    logic [3:0]        mistakes;
    logic              state_chg;

    modport master (
        output mouse_left, mouse_on_btn, board_valid, entry_wrong,
        input  state, game_init, level, elapsed_sec, mistakes, state_chg
    );

    modport slave (
        input  mouse_left, mouse_on_btn, board_valid, entry_wrong,
        output state, game_init, level, elapsed_sec, mistakes, state_chg
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game state sequencer with click decode, difficulty, seconds timer and mistake limit
module game_flow_ctrl #(
    parameter int CLK_HZ       = 100000000,
    parameter int TIME_W       = 12,
    parameter int LEVELS       = 3,
    parameter int LVL_W        = 2,
    parameter int MAX_MISTAKES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    game_flow_ctrl_if.slave bus
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);
    localparam logic [3:0]       MIS_MAX  = 4'(MAX_MISTAKES);
    localparam logic [3:0]       MIS_PRE  = 4'(MAX_MISTAKES - 1);

    typedef enum logic [2:0] {
        S_MENU  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              ml_q, ml_d;
    logic [3:0]        cap_q, cap_d;
    logic [3:0]        click_q, click_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [TIME_W-1:0] sec_q, sec_d;
    logic [3:0]        mis_q, mis_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              init_q, init_d;
    logic              chg_q, chg_d;

    always_comb begin
        ml_d    = bus.mouse_left;
        cap_d   = cap_q;
        click_d = '0;
        // A click needs press and release on the same button; dragging off cancels it.
        if (bus.mouse_left && !ml_q) begin
            cap_d = bus.mouse_on_btn;
        end else if (!bus.mouse_left && ml_q) begin
            click_d = cap_q & bus.mouse_on_btn;
            cap_d   = '0;
        end

        state_d = state_q;
        level_d = level_q;
        sec_d   = sec_q;
        mis_d   = mis_q;
        presc_d = presc_q;
        case (state_q)
            S_MENU: begin
                if (click_q[0]) begin
                    state_d = S_PLAY;
                    sec_d   = '0;
                    mis_d   = '0;
                    presc_d = '0;
                end else if (click_q[3]) begin
                    level_d = (level_q == LVL_LAST) ? '0 : level_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.entry_wrong && mis_q != MIS_MAX) mis_d = mis_q + 1'b1;
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    if (!(&sec_q)) sec_d = sec_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (bus.board_valid)                          state_d = S_WIN;
                else if (bus.entry_wrong && mis_q == MIS_PRE) state_d = S_LOSE;
                else if (click_q[2])                          state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (click_q[2])      state_d = S_PLAY;
                else if (click_q[1]) state_d = S_MENU;
            end
            S_WIN, S_LOSE: begin
                if (click_q[1]) state_d = S_MENU;
            end
            default: state_d = S_MENU;
        endcase

        init_d = (state_d == S_MENU) || (state_d == S_WIN) || (state_d == S_LOSE);
        chg_d  = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_MENU;
            ml_q    <= 1'b0;
            cap_q   <= '0;
            click_q <= '0;
            level_q <= '0;
            sec_q   <= '0;
            mis_q   <= '0;
            presc_q <= '0;
            init_q  <= 1'b1;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ml_q    <= ml_d;
            cap_q   <= cap_d;
            click_q <= click_d;
            level_q <= level_d;
            sec_q   <= sec_d;
            mis_q   <= mis_d;
            presc_q <= presc_d;
            init_q  <= init_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.game_init   = init_q;
    assign bus.level       = level_q;
    assign bus.elapsed_sec = sec_q;
    assign bus.mistakes    = mis_q;
    assign bus.state_chg   = chg_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl with a behavioural game model
module tb_game_flow_ctrl;
    localparam int CLK_HZ = 10;
    localparam int LEVELS = 3;
    localparam int MAXM   = 3;
    localparam int TIME_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    game_flow_ctrl_if #(.TIME_W(TIME_W), .LVL_W(2)) bus ();
    game_flow_ctrl_if #(.TIME_W(2), .LVL_W(2)) bus2 ();

    game_flow_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(TIME_W), .LEVELS(LEVELS), .LVL_W(2), .MAX_MISTAKES(MAXM))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    game_flow_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(2), .LEVELS(LEVELS), .LVL_W(2), .MAX_MISTAKES(MAXM))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Reference game model: integers for every counter, a pending-click set, one step per clock.
    int         m_state, m_level, m_sec, m_presc, m_mis, m_chg;
    logic       m_ml;
    logic [3:0] m_cap, m_click;

    task automatic model_step();
        logic [3:0] c;
        int         prev;
        bit         lose;
        if (!rst_n) begin
            m_state = 0; m_level = 0; m_sec = 0; m_presc = 0; m_mis = 0; m_chg = 0;
            m_ml = 1'b0; m_cap = 4'd0; m_click = 4'd0;
            return;
        end
        c = m_click;
        m_click = 4'd0;
        if (bus.mouse_left && !m_ml) m_cap = bus.mouse_on_btn;
        else if (!bus.mouse_left && m_ml) begin
            m_click = m_cap & bus.mouse_on_btn;
            m_cap = 4'd0;
        end
        m_ml = bus.mouse_left;
        prev = m_state;
        case (m_state)
            0: if (c[0]) begin
                   m_state = 1; m_sec = 0; m_mis = 0; m_presc = 0;
               end else if (c[3]) m_level = (m_level + 1) % LEVELS;
            1: begin
                lose = bus.entry_wrong && (m_mis + 1 == MAXM);
                if (bus.entry_wrong && m_mis < MAXM) m_mis = m_mis + 1;
                m_presc = m_presc + 1;
                if (m_presc == CLK_HZ) begin
                    m_presc = 0;
                    if (m_sec < (1 << TIME_W) - 1) m_sec = m_sec + 1;
                end
                if (bus.board_valid) m_state = 3;
                else if (lose)       m_state = 4;
                else if (c[2])       m_state = 2;
            end
            2: if (c[2]) m_state = 1; else if (c[1]) m_state = 0;
            3, 4: if (c[1]) m_state = 0;
            default: m_state = 0;
        endcase
        m_chg = (m_state != prev) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic click(input logic [3:0] press_btn, input logic [3:0] rel_btn);
        bus.mouse_on_btn = press_btn;
        bus.mouse_left   = 1'b1;
        tick();
        bus.mouse_on_btn = rel_btn;
        bus.mouse_left   = 1'b0;
        tick();
        bus.mouse_on_btn = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.game_init !== 1'b1 || bus.level !== 2'd0 ||
            bus.elapsed_sec !== 12'd0 || bus.mistakes !== 4'd0 || bus.state_chg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d init=%0d level=%0d sec=%0d mis=%0d chg=%0d, required 0 1 0 0 0 0",
                     bus.state, bus.game_init, bus.level, bus.elapsed_sec, bus.mistakes, bus.state_chg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_level_start();
        int exp_lvl [3] = '{1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            click(4'b1000, 4'b1000);
            tick();
            n_tests++;
            if (bus.level !== 2'(exp_lvl[i]) || bus.state !== 3'd0) begin
                n_fail++;
                $display("FAIL level_cycle_%0d: level=%0d state=%0d, required level=%0d state=0",
                         i, bus.level, bus.state, exp_lvl[i]);
            end
        end
        click(4'b0001, 4'b0000);
        tick();
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL drag_off: state=%0d, required 0", bus.state);
        end
        click(4'b0001, 4'b0001);
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL start_early: state=%0d at release sample, required 0", bus.state);
        end
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || bus.state_chg !== 1'b1 || bus.game_init !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency: state=%0d chg=%0d init=%0d, required 1 1 0",
                     bus.state, bus.state_chg, bus.game_init);
        end
        tick();
        n_tests++;
        if (bus.state_chg !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_pulse: state_chg=%0d one cycle later, required 0", bus.state_chg);
        end
    endtask

    task automatic test_timer_pause();
        repeat (34) tick();
        n_tests++;
        if (bus.elapsed_sec !== 12'd3) begin
            n_fail++;
            $display("FAIL play_35_cycles: elapsed_sec=%0d, required 3", bus.elapsed_sec);
        end
        click(4'b0100, 4'b0100);
        tick();
        n_tests++;
        if (bus.state !== 3'd2) begin
            n_fail++;
            $display("FAIL pause: state=%0d, required 2", bus.state);
        end
        repeat (100) tick();
        n_tests++;
        if (bus.elapsed_sec !== 12'd3 || bus.state !== 3'd2) begin
            n_fail++;
            $display("FAIL pause_hold: elapsed_sec=%0d state=%0d, required 3 2", bus.elapsed_sec, bus.state);
        end
        click(4'b0100, 4'b0100);
        tick();
        n_tests++;
        if (bus.state !== 3'd1) begin
            n_fail++;
            $display("FAIL resume: state=%0d, required 1", bus.state);
        end
        tick();
        n_tests++;
        if (bus.elapsed_sec !== 12'd3) begin
            n_fail++;
            $display("FAIL resume_partial_1: elapsed_sec=%0d, required 3", bus.elapsed_sec);
        end
        repeat (4) tick();
        n_tests++;
        if (bus.elapsed_sec !== 12'd4) begin
            n_fail++;
            $display("FAIL resume_partial_5: elapsed_sec=%0d, required 4", bus.elapsed_sec);
        end
    endtask

    task automatic test_mistakes();
        for (int k = 1; k <= 3; k++) begin
            bus.entry_wrong = 1'b1;
            tick();
            bus.entry_wrong = 1'b0;
            n_tests++;
            if (bus.mistakes !== 4'(k) || bus.state !== ((k == 3) ? 3'd4 : 3'd1)) begin
                n_fail++;
                $display("FAIL mistake_%0d: mistakes=%0d state=%0d, required %0d %0d",
                         k, bus.mistakes, bus.state, k, (k == 3) ? 4 : 1);
            end
            tick();
        end
        bus.entry_wrong = 1'b1;
        tick();
        tick();
        bus.entry_wrong = 1'b0;
        tick();
        n_tests++;
        if (bus.mistakes !== 4'd3 || bus.state !== 3'd4 || bus.game_init !== 1'b1) begin
            n_fail++;
            $display("FAIL mistake_sat: mistakes=%0d state=%0d init=%0d, required 3 4 1",
                     bus.mistakes, bus.state, bus.game_init);
        end
        click(4'b0010, 4'b0010);
        tick();
        n_tests++;
        if (bus.state !== 3'd0 || bus.state_chg !== 1'b1 || bus.mistakes !== 4'd3) begin
            n_fail++;
            $display("FAIL lose_return: state=%0d chg=%0d mistakes=%0d, required 0 1 3",
                     bus.state, bus.state_chg, bus.mistakes);
        end
    endtask

    task automatic test_coincident();
        click(4'b0001, 4'b0001);
        tick();
        n_tests++;
        if (bus.state !== 3'd1 || bus.mistakes !== 4'd0 || bus.elapsed_sec !== 12'd0) begin
            n_fail++;
            $display("FAIL restart_clear: state=%0d mistakes=%0d sec=%0d, required 1 0 0",
                     bus.state, bus.mistakes, bus.elapsed_sec);
        end
        repeat (2) begin
            bus.entry_wrong = 1'b1;
            tick();
            bus.entry_wrong = 1'b0;
            tick();
        end
        bus.entry_wrong = 1'b1;
        bus.board_valid = 1'b1;
        tick();
        bus.entry_wrong = 1'b0;
        bus.board_valid = 1'b0;
        n_tests++;
        if (bus.state !== 3'd3 || bus.mistakes !== 4'd3 || bus.game_init !== 1'b1) begin
            n_fail++;
            $display("FAIL win_coincident: state=%0d mistakes=%0d init=%0d, required 3 3 1",
                     bus.state, bus.mistakes, bus.game_init);
        end
        click(4'b0010, 4'b0010);
        tick();
        n_tests++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL win_return: state=%0d, required 0", bus.state);
        end
    endtask

    task automatic test_saturation();
        bus2.mouse_on_btn = 4'b0001;
        bus2.mouse_left   = 1'b1;
        tick();
        bus2.mouse_left   = 1'b0;
        tick();
        tick();
        bus2.mouse_on_btn = 4'b0000;
        n_tests++;
        if (bus2.state !== 3'd1) begin
            n_fail++;
            $display("FAIL sat_start: state=%0d, required 1", bus2.state);
        end
        repeat (25) tick();
        n_tests++;
        if (bus2.elapsed_sec !== 2'd2) begin
            n_fail++;
            $display("FAIL sat_2s: elapsed_sec=%0d, required 2", bus2.elapsed_sec);
        end
        repeat (35) tick();
        n_tests++;
        if (bus2.elapsed_sec !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_6s: elapsed_sec=%0d, required 3", bus2.elapsed_sec);
        end
        repeat (20) tick();
        n_tests++;
        if (bus2.elapsed_sec !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_hold: elapsed_sec=%0d, required 3", bus2.elapsed_sec);
        end
    endtask

    task automatic test_reset_mid();
        click(4'b1000, 4'b1000);
        tick();
        click(4'b0001, 4'b0001);
        tick();
        bus.entry_wrong = 1'b1;
        tick();
        bus.entry_wrong = 1'b0;
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (bus.state !== 3'd0 || bus.game_init !== 1'b1 || bus.level !== 2'd0 ||
            bus.elapsed_sec !== 12'd0 || bus.mistakes !== 4'd0 || bus.state_chg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_play: state=%0d init=%0d level=%0d sec=%0d mis=%0d chg=%0d, required 0 1 0 0 0 0",
                     bus.state, bus.game_init, bus.level, bus.elapsed_sec, bus.mistakes, bus.state_chg);
        end
    endtask

    task automatic test_random();
        logic [3:0] pick [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        int exp_init;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(2) == 0) bus.mouse_left = ~bus.mouse_left;
            if ($urandom_range(3) == 0) bus.mouse_on_btn = pick[$urandom_range(4)];
            bus.board_valid = ($urandom_range(59) == 0);
            bus.entry_wrong = ($urandom_range(7) == 0);
            rst_n = ($urandom_range(799) != 0);
            tick();
            exp_init = (m_state == 0 || m_state == 3 || m_state == 4) ? 1 : 0;
            n_tests++;
            if (bus.state !== 3'(m_state) || bus.game_init !== 1'(exp_init) ||
                bus.level !== 2'(m_level) || bus.elapsed_sec !== 12'(m_sec) ||
                bus.mistakes !== 4'(m_mis) || bus.state_chg !== 1'(m_chg)) begin
                n_fail++;
                $display("FAIL random_cyc_%0d: state=%0d init=%0d level=%0d sec=%0d mis=%0d chg=%0d, required %0d %0d %0d %0d %0d %0d",
                         cyc, bus.state, bus.game_init, bus.level, bus.elapsed_sec, bus.mistakes, bus.state_chg,
                         m_state, exp_init, m_level, m_sec, m_mis, m_chg);
            end
        end
        rst_n = 1'b1;
        bus.mouse_left = 1'b0;
        bus.mouse_on_btn = 4'd0;
        bus.board_valid = 1'b0;
        bus.entry_wrong = 1'b0;
    endtask

    initial begin
        bus.mouse_left = 1'b0;
        bus.mouse_on_btn = 4'd0;
        bus.board_valid = 1'b0;
        bus.entry_wrong = 1'b0;
        bus2.mouse_left = 1'b0;
        bus2.mouse_on_btn = 4'd0;
        bus2.board_valid = 1'b0;
        bus2.entry_wrong = 1'b0;
        m_state = 0; m_level = 0; m_sec = 0; m_presc = 0; m_mis = 0; m_chg = 0;
        m_ml = 1'b0; m_cap = 4'd0; m_click = 4'd0;

        test_reset();
        test_level_start();
        test_timer_pause();
        test_mistakes();
        test_coincident();
        test_saturation();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
